// File: rtl/parallel_serial_if.sv
// Word handshake in, serial bit stream out, for the byte-to-bit serializer.
// The master side supplies words; the slave side is the serializer itself.
interface parallel_serial_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       byte_start;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  byte_start
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output byte_start
  );
endinterface

// File: rtl/parallel_serial.sv
// Byte-to-bit serializer: shifts 8-bit words out MSB first, one bit per clock.
// It sends alignment COM symbols after reset and fills idle time with COM.
module parallel_serial #(
  parameter int         SYNC_SYMBOLS = 4,
  parameter logic [7:0] COM_SYMBOL   = 8'hBC
) (
  input  logic             clk,
  input  logic             rst_n,
  parallel_serial_if.slave ps
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_SYMBOLS - 1);

  typedef enum logic {SYNC, DATA} state_t;

  state_t     state_reg, state_next;
  logic [7:0] cur_reg, cur_next;
  logic [7:0] hold_reg, hold_next;
  logic       hold_full_reg, hold_full_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [3:0] sync_cnt_reg, sync_cnt_next;
  logic       data_out_reg, data_out_next;
  logic       byte_start_reg, byte_start_next;

  logic [7:0] cur_rev;
  logic       sym_end;
  logic       ready;
  logic       accept;

  // Bit-reversed view so the bit counter indexes MSB first directly.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rev
    assign cur_rev[gi] = cur_reg[7 - gi];
  end

  assign sym_end = (bit_cnt_reg == 3'd7);
  // A word may land in hold at the same edge hold drains into cur.
  assign ready   = (state_reg == DATA) && (!hold_full_reg || sym_end);
  assign accept  = ready && ps.valid_in;

  assign ps.ready_out  = ready;
  assign ps.data_out   = data_out_reg;
  assign ps.byte_start = byte_start_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= SYNC;
      cur_reg        <= COM_SYMBOL;
      hold_reg       <= 8'h00;
      hold_full_reg  <= 1'b0;
      bit_cnt_reg    <= 3'd0;
      sync_cnt_reg   <= 4'd0;
      data_out_reg   <= 1'b0;
      byte_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      hold_reg       <= hold_next;
      hold_full_reg  <= hold_full_next;
      bit_cnt_reg    <= bit_cnt_next;
      sync_cnt_reg   <= sync_cnt_next;
      data_out_reg   <= data_out_next;
      byte_start_reg <= byte_start_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cur_next        = cur_reg;
    hold_next       = hold_reg;
    hold_full_next  = hold_full_reg;
    bit_cnt_next    = bit_cnt_reg + 3'd1;
    sync_cnt_next   = sync_cnt_reg;
    data_out_next   = cur_rev[bit_cnt_reg];
    byte_start_next = (bit_cnt_reg == 3'd0);

    if (sym_end) begin
      cur_next       = hold_full_reg ? hold_reg : COM_SYMBOL;
      hold_full_next = 1'b0;
    end

    case (state_reg)
      SYNC: begin
        if (sym_end) begin
          sync_cnt_next = sync_cnt_reg + 4'd1;
          if (sync_cnt_reg == SYNC_LAST) begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          hold_next      = ps.data_in;
          hold_full_next = 1'b1;
        end
      end
      default: state_next = SYNC;
    endcase
  end

endmodule

// File: tb/tb_parallel_serial.sv
// Directed bench for parallel_serial: a scoreboard of expected symbols keyed by
// start edge, checked against a serial monitor that re-assembles the stream.
module tb_parallel_serial;

  localparam logic [7:0] COM = 8'hBC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parallel_serial_if ps_if ();

  parallel_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ps    (ps_if)
  );

  typedef struct {
    logic [7:0] sym;
    int         start;
  } exp_t;

  exp_t sb[$];

  int         checks   = 0;
  int         failures = 0;
  int         edge_n;
  logic [7:0] sh;
  logic [7:0] exp_sym;
  int         nbits     = 0;
  int         sym_start = 0;
  bit         aligned   = 1'b0;
  int         acc;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h at edge %0d", name, obs, expv, edge_n);
      $error("check %s", name);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  // Serial monitor: rebuilds symbols on byte_start boundaries.
  always @(negedge clk) begin
    if (!rst_n) begin
      nbits   = 0;
      aligned = 1'b0;
    end else if (ps_if.byte_start) begin
      chk("byte_start_period", nbits, 0);
      chk("byte_start_phase", edge_n % 8, 1);
      sh        = {7'd0, ps_if.data_out};
      nbits     = 1;
      sym_start = edge_n;
      aligned   = 1'b1;
    end else if (aligned) begin
      if (nbits == 0) chk("byte_start_missing", ps_if.byte_start, 1);
      sh    = {sh[6:0], ps_if.data_out};
      nbits = nbits + 1;
    end
    if (nbits == 8) begin
      exp_sym = COM;
      if (sb.size() > 0 && sb[0].start == sym_start) begin
        exp_sym = sb[0].sym;
        void'(sb.pop_front());
      end
      if (sb.size() > 0) chk("sb_order", sb[0].start > sym_start, 1);
      chk($sformatf("symbol@%0d", sym_start), sh, exp_sym);
      $display("symbol start=%0d got=%02h exp=%02h", sym_start, sh, exp_sym);
      nbits = 0;
    end
  end

  task automatic do_reset();
    ps_if.valid_in = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_data_out", ps_if.data_out, 0);
    chk("rst_ready", ps_if.ready_out, 0);
    chk("rst_byte_start", ps_if.byte_start, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_sync(input bit v);
    ps_if.valid_in = v;
    ps_if.data_in  = 8'h55;
    for (int k = 0; k < 40 && edge_n < 32; k++) begin
      @(posedge clk);
      #1;
      chk("ready_sync", ps_if.ready_out, (edge_n >= 32) ? 1 : 0);
    end
    ps_if.valid_in = 1'b0;
  endtask

  // Word accepted at edge a starts on the edge after the next multiple of 8 above a.
  task automatic send(input logic [7:0] b, output int acc_edge);
    bit r;
    acc_edge       = -1;
    ps_if.data_in  = b;
    ps_if.valid_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r = ps_if.ready_out;
      @(posedge clk);
      #1;
      if (r) begin
        acc_edge = edge_n;
        break;
      end
    end
    chk("accept_timeout", (acc_edge >= 0) ? 1 : 0, 1);
    if (acc_edge >= 0) sb.push_back('{sym: b, start: ((acc_edge / 8) + 1) * 8 + 1});
    $display("send %02h accepted at edge %0d", b, acc_edge);
  endtask

  task automatic wait_edge(input int n);
    for (int k = 0; k < 300 && edge_n < n; k++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_edge", edge_n, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ps_if.valid_in = 1'b0;
    ps_if.data_in  = 8'h00;

    // Valid held during sync: nothing accepted, COM only.
    do_reset();
    run_sync(1'b1);

    // Single word after sync.
    send(8'hA5, acc);
    ps_if.valid_in = 1'b0;
    chk("a5_accept_edge", acc, 33);
    for (int e = 34; e <= 39; e++) begin
      chk("ready_while_hold", ps_if.ready_out, 0);
      @(posedge clk);
      #1;
    end
    chk("ready_at_load", ps_if.ready_out, 1);

    // Back-to-back words.
    wait_edge(55);
    send(8'h01, acc);
    chk("b2b_accept0", acc, 56);
    send(8'h80, acc);
    chk("b2b_accept1", acc, 64);
    send(8'hFF, acc);
    chk("b2b_accept2", acc, 72);
    ps_if.valid_in = 1'b0;
    wait_edge(100);
    chk("sb_drained_a", sb.size(), 0);

    // Fresh sync with valid low, then two words recovered in order.
    do_reset();
    run_sync(1'b0);
    send(8'h3C, acc);
    chk("loop_accept0", acc, 33);
    send(8'hC3, acc);
    chk("loop_accept1", acc, 40);
    ps_if.valid_in = 1'b0;
    wait_edge(70);
    chk("sb_drained_b", sb.size(), 0);

    // Reset mid-symbol with hold full; pending word must never appear.
    do_reset();
    run_sync(1'b0);
    send(8'h5A, acc);
    chk("trunc_accept0", acc, 33);
    send(8'h96, acc);
    chk("trunc_accept1", acc, 40);
    ps_if.valid_in = 1'b0;
    wait_edge(44);
    chk("pre_reset_bit", ps_if.data_out, 1);
    do_reset();
    run_sync(1'b0);
    wait_edge(64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
